// File: rtl/dcache_pkg.sv
// dcache_pkg: shared FSM state type and RISC-V func3 codes for the data cache
package dcache_pkg;
    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_e;
    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;
    localparam logic [2:0] SB  = 3'd0;
    localparam logic [2:0] SH  = 3'd1;
    localparam logic [2:0] SW  = 3'd2;
endpackage

// File: rtl/dcache_align.sv
// dcache_align: load extract/extend and store byte-merge on one 32-bit cached word
// Ports: func3_i width/sign code, off_i byte offset, word_i cached word,
//        wdata_i LSB-aligned store data, load_o extended load, store_o merged word
module dcache_align
    import dcache_pkg::*;
(
    input  logic [2:0]  func3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] store_o
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    always_comb begin
        byte_v  = word_i[8*off_i +: 8];
        half_v  = off_i[1] ? word_i[31:16] : word_i[15:0];
        load_o  = func3_i == LB  ? {{24{byte_v[7]}}, byte_v} :
                  func3_i == LH  ? {{16{half_v[15]}}, half_v} :
                  func3_i == LW  ? word_i :
                  func3_i == LBU ? {24'b0, byte_v} :
                  func3_i == LHU ? {16'b0, half_v} : '0;
        store_o = word_i;
        if (func3_i == SB)
            store_o[8*off_i +: 8] = wdata_i[7:0];
        else if (func3_i == SH)
            store_o[16*off_i[1] +: 16] = wdata_i[15:0];
        else
            store_o = wdata_i;
    end
endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped write-back write-allocate data cache, one word per line
// Ports: clk/rst (async active-high); req_* memory-stage request; stall freezes the pipeline;
//        rdata extended load result; mem_* word port to data memory (wen writeback, ren refill).
// Optional: define DCACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int SETS        = 8,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [2:0]            func3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wen,
    output logic                  mem_ren,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);
    localparam int IW = $clog2(SETS);
    localparam int TW = ADDR_WIDTH - IW - 2;
    localparam int CW = $clog2(MEM_LATENCY) + 1;
    localparam logic [CW-1:0] LAST = CW'(MEM_LATENCY - 1);

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q [SETS];
    logic [TW-1:0]         tag_q [SETS];
    logic [SETS-1:0]       valid_q, dirty_q;
    logic [ADDR_WIDTH-3:0] miss_q;
    logic [IW-1:0]         idx, midx;
    logic [TW-1:0]         tag;
    logic                  hit, miss, last, st_hit;
    logic [DATA_WIDTH-1:0] ld_word, st_word;

    dcache_align u_align (
        .func3_i (func3),
        .off_i   (req_addr[1:0]),
        .word_i  (data_q[idx]),
        .wdata_i (req_wdata),
        .load_o  (ld_word),
        .store_o (st_word)
    );

    always_comb begin
        idx     = req_addr[2 +: IW];
        tag     = req_addr[ADDR_WIDTH-1 -: TW];
        midx    = miss_q[IW-1:0];
        hit     = req_valid && valid_q[idx] && tag_q[idx] == tag;
        miss    = state_q == IDLE && req_valid && !hit;
        st_hit  = state_q == IDLE && hit && req_write;
        last    = cnt_q == LAST;
        state_d = state_q == IDLE ? (miss ? (valid_q[idx] && dirty_q[idx] ? WRITEBACK : REFILL) : IDLE) :
                  !last ? state_q :
                  state_q == WRITEBACK ? REFILL : IDLE;
        cnt_d   = (state_q == IDLE || last) ? '0 : cnt_q + 1'b1;
        // stall held low during reset so the pipeline sees a quiet cache
        stall     = !rst && (miss || state_q != IDLE);
        mem_wen   = state_q == WRITEBACK && cnt_q == '0;
        mem_ren   = state_q == REFILL;
        mem_addr  = state_q == WRITEBACK ? {tag_q[midx], midx, 2'b00} :
                    state_q == REFILL    ? {miss_q, 2'b00} : '0;
        mem_wdata = state_q == WRITEBACK ? data_q[midx] : '0;
        rdata     = (state_q == IDLE && hit && !req_write) ? ld_word : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= '0;
            dirty_q <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (miss)
                miss_q <= req_addr[ADDR_WIDTH-1:2];
            if (st_hit)
                dirty_q[idx] <= 1'b1;
            if (state_q != IDLE && last)
                dirty_q[midx] <= 1'b0;
            if (state_q == REFILL && last)
                valid_q[midx] <= 1'b1;
        end
    end

    // line storage needs no reset: valid gates every use
    always_ff @(posedge clk) begin
        if (st_hit)
            data_q[idx] <= st_word;
        if (state_q == REFILL && last) begin
            data_q[midx] <= mem_rdata;
            tag_q[midx]  <= miss_q[ADDR_WIDTH-3 -: TW];
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (state_q == IDLE && hit && hit_count != '1)
                hit_count <= hit_count + 1'b1;
            if (miss && miss_count != '1)
                miss_count <= miss_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: randomized self-checking bench against a flat-memory reference model
module tb_dcache_controller;
    localparam int L = 2;
    localparam int S = 8;

    logic        clk = 0, rst = 1;
    logic        req_valid = 0, req_write = 0;
    logic [2:0]  func3 = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic        stall, mem_wen, mem_ren;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 0;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    int compared = 0, mismatched = 0;
    int wen_cnt = 0, ren_cnt = 0;
    logic [31:0] wen_addr = 0, wen_data = 0, ren_addr = 0;

    logic [31:0] bmem [logic [31:0]];
    logic [31:0] amem [logic [31:0]];
    logic        mv [S];
    logic        md [S];
    int          mt [S];

    dcache_controller dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write), .func3(func3),
        .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall), .rdata(rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_ren(mem_ren),
        .mem_rdata(mem_rdata)
`ifdef DCACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] bm_rd(logic [31:0] a);
        return bmem.exists(a) ? bmem[a] : a * 32'h9E37_79B1 + 32'h1357_2468;
    endfunction

    function automatic logic [31:0] arch_rd(logic [31:0] a);
        return amem.exists(a) ? amem[a] : bm_rd(a);
    endfunction

    function automatic logic [31:0] ld_ref(logic [31:0] w, logic [2:0] f, logic [1:0] o);
        logic [31:0] b, h;
        b = (w >> (8 * o)) & 32'hFF;
        h = o[1] ? (w >> 16) : (w & 32'hFFFF);
        case (f)
            3'd0: return b[7] ? (b | 32'hFFFF_FF00) : b;
            3'd1: return h[15] ? (h | 32'hFFFF_0000) : h;
            3'd2: return w;
            3'd4: return b;
            3'd5: return h;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] st_ref(logic [31:0] w, logic [2:0] f, logic [1:0] o, logic [31:0] d);
        logic [31:0] m, v;
        if (f == 3'd0) begin
            m = 32'hFF << (8 * o);
            v = (d & 32'hFF) << (8 * o);
        end else if (f == 3'd1) begin
            m = 32'hFFFF << (o[1] ? 16 : 0);
            v = (d & 32'hFFFF) << (o[1] ? 16 : 0);
        end else begin
            m = 32'hFFFF_FFFF;
            v = d;
        end
        return (w & ~m) | (v & m);
    endfunction

    // expected stall cycles for an access, then record the line as resident
    function automatic int predict(logic w, logic [31:0] a);
        int s = int'((a >> 2) % S);
        int t = int'(a >> 5);
        int c;
        if (mv[s] && mt[s] == t) c = 0;
        else c = (mv[s] && md[s]) ? 2 * L + 1 : L + 1;
        md[s] = (c != 0) ? w : (md[s] | w);
        mv[s] = 1;
        mt[s] = t;
        return c;
    endfunction

    always @(negedge clk) begin
        if (mem_wen) begin
            bmem[mem_addr] = mem_wdata;
            wen_cnt++;
            wen_addr = mem_addr;
            wen_data = mem_wdata;
        end
        if (mem_ren) begin
            ren_cnt++;
            ren_addr = mem_addr;
        end
        if (mem_wen || mem_ren) begin
            compared++;
            if (mem_wen && mem_ren) begin
                mismatched++;
                $display("FAIL wen_ren_exclusive: both high at addr %h", mem_addr);
            end
        end
        mem_rdata = bm_rd(mem_addr);
    end

    task automatic access(input logic w, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] wd, output int cyc, output logic [31:0] rd);
        @(negedge clk);
        req_valid = 1; req_write = w; func3 = f; req_addr = a; req_wdata = wd;
        #1;
        cyc = 0;
        while (stall && cyc < 50) begin
            cyc++;
            @(negedge clk);
            #1;
        end
        rd = rdata;
        @(posedge clk);
        #1;
        req_valid = 0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1; req_valid = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        for (int i = 0; i < S; i++) begin mv[i] = 0; md[i] = 0; mt[i] = 0; end
        amem.delete();
    endtask

    task automatic test_reset;
        req_valid = 1; func3 = 3'd2; req_addr = 32'h0001_0000;
        #12;
        compared += 6;
        if (stall !== 1'b0) begin mismatched++; $display("FAIL reset_stall: got %b want 0", stall); end
        if (mem_wen !== 1'b0) begin mismatched++; $display("FAIL reset_wen: got %b want 0", mem_wen); end
        if (mem_ren !== 1'b0) begin mismatched++; $display("FAIL reset_ren: got %b want 0", mem_ren); end
        if (mem_addr !== 32'h0) begin mismatched++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
        if (mem_wdata !== 32'h0) begin mismatched++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
        if (rdata !== 32'h0) begin mismatched++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        req_valid = 0;
        @(negedge clk);
        rst = 0;
        #1;
        compared++;
        if (stall !== 1'b0) begin mismatched++; $display("FAIL idle_stall: got %b want 0", stall); end
    endtask

    task automatic test_directed;
        int c, w0, r0;
        logic [31:0] d;
        bmem[32'h0001_0000] = 32'h80FF_1234;
        w0 = wen_cnt; r0 = ren_cnt;
        access(0, 3'd2, 32'h0001_0000, 0, c, d);
        compared += 5;
        if (c != 3) begin mismatched++; $display("FAIL lw_miss_cycles: got %0d want 3", c); end
        if (d !== 32'h80FF_1234) begin mismatched++; $display("FAIL lw_miss_data: got %h want 80ff1234", d); end
        if (ren_cnt - r0 != 2) begin mismatched++; $display("FAIL lw_miss_ren: got %0d want 2", ren_cnt - r0); end
        if (ren_addr !== 32'h0001_0000) begin mismatched++; $display("FAIL lw_miss_addr: got %h want 00010000", ren_addr); end
        if (wen_cnt != w0) begin mismatched++; $display("FAIL lw_miss_wen: got %0d want 0", wen_cnt - w0); end
        access(0, 3'd0, 32'h0001_0003, 0, c, d);
        compared += 2;
        if (c != 0) begin mismatched++; $display("FAIL lb_hit_cycles: got %0d want 0", c); end
        if (d !== 32'hFFFF_FF80) begin mismatched++; $display("FAIL lb_hit_data: got %h want ffffff80", d); end
        access(0, 3'd4, 32'h0001_0003, 0, c, d);
        compared++;
        if (d !== 32'h0000_0080) begin mismatched++; $display("FAIL lbu_hit_data: got %h want 00000080", d); end
        access(1, 3'd0, 32'h0001_0001, 32'h0000_00AB, c, d);
        compared++;
        if (c != 0) begin mismatched++; $display("FAIL sb_hit_cycles: got %0d want 0", c); end
        access(0, 3'd2, 32'h0001_0000, 0, c, d);
        compared++;
        if (d !== 32'h80FF_AB34) begin mismatched++; $display("FAIL sb_merge: got %h want 80ffab34", d); end
        w0 = wen_cnt; r0 = ren_cnt;
        access(0, 3'd2, 32'h0001_0020, 0, c, d);
        compared += 6;
        if (c != 5) begin mismatched++; $display("FAIL dirty_miss_cycles: got %0d want 5", c); end
        if (wen_cnt - w0 != 1) begin mismatched++; $display("FAIL dirty_wen_count: got %0d want 1", wen_cnt - w0); end
        if (wen_addr !== 32'h0001_0000) begin mismatched++; $display("FAIL wb_addr: got %h want 00010000", wen_addr); end
        if (wen_data !== 32'h80FF_AB34) begin mismatched++; $display("FAIL wb_data: got %h want 80ffab34", wen_data); end
        if (ren_cnt - r0 != 2) begin mismatched++; $display("FAIL dirty_ren_count: got %0d want 2", ren_cnt - r0); end
        if (d !== bm_rd(32'h0001_0020)) begin mismatched++; $display("FAIL dirty_miss_data: got %h want %h", d, bm_rd(32'h0001_0020)); end
    endtask

    task automatic test_reset_mid;
        int c;
        logic [31:0] d;
        @(negedge clk);
        req_valid = 1; req_write = 0; func3 = 3'd2; req_addr = 32'h0001_0040;
        #1;
        compared += 2;
        if (stall !== 1'b1) begin mismatched++; $display("FAIL mid_stall: got %b want 1", stall); end
        @(posedge clk);
        #1;
        if (mem_ren !== 1'b1 || mem_addr !== 32'h0001_0040) begin
            mismatched++; $display("FAIL mid_refill: ren %b addr %h want 1 00010040", mem_ren, mem_addr);
        end
        rst = 1;
        #1;
        compared += 2;
        if (mem_ren !== 1'b0) begin mismatched++; $display("FAIL mid_ren_drop: got %b want 0", mem_ren); end
        if (mem_addr !== 32'h0) begin mismatched++; $display("FAIL mid_addr_drop: got %h want 0", mem_addr); end
        req_valid = 0;
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < S; i++) begin mv[i] = 0; md[i] = 0; end
        amem.delete();
        access(0, 3'd2, 32'h0001_0040, 0, c, d);
        compared += 2;
        if (c != 3) begin mismatched++; $display("FAIL post_rst_miss: got %0d want 3", c); end
        if (d !== bm_rd(32'h0001_0040)) begin mismatched++; $display("FAIL post_rst_data: got %h want %h", d, bm_rd(32'h0001_0040)); end
        access(0, 3'd2, 32'h0001_0020, 0, c, d);
        compared++;
        if (c != 3) begin mismatched++; $display("FAIL post_rst_inval: got %0d want 3", c); end
    endtask

    task automatic test_random;
        int c, ec;
        logic [31:0] a, aw, wd, d, exp;
        logic [2:0] f;
        logic w;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            a = 32'h0002_0000 | (($urandom % 4) << 5) | (($urandom % 8) << 2) | ($urandom % 4);
            aw = a & ~32'h3;
            w = 1'($urandom % 2);
            f = 3'($urandom % 8);
            wd = $urandom;
            ec = predict(w, a);
            exp = ld_ref(arch_rd(aw), f, a[1:0]);
            if (w) amem[aw] = st_ref(arch_rd(aw), f, a[1:0], wd);
            access(w, f, a, wd, c, d);
            compared++;
            if (c != ec) begin mismatched++; $display("FAIL rand_cycles[%0d]: addr %h got %0d want %0d", n, a, c, ec); end
            if (!w) begin
                compared++;
                if (d !== exp) begin mismatched++; $display("FAIL rand_load[%0d]: addr %h f3 %0d got %h want %h", n, a, f, d, exp); end
            end
        end
    endtask

    task automatic test_back_to_back;
        int c;
        logic [31:0] d;
        for (int n = 0; n < 4; n++) begin
            access(1, 3'd2, 32'h0002_0000 + 32'(n) * 4, 32'hC0DE_0000 + 32'(n), c, d);
        end
        for (int n = 0; n < 4; n++) begin
            access(0, 3'd2, 32'h0002_0000 + 32'(n) * 4, 0, c, d);
            compared++;
            if (d !== 32'hC0DE_0000 + 32'(n)) begin mismatched++; $display("FAIL b2b_load[%0d]: got %h want %h", n, d, 32'hC0DE_0000 + 32'(n)); end
        end
    endtask

`ifdef DCACHE_STATS_EN
    task automatic test_stats;
        int c;
        logic [31:0] d;
        do_reset();
        access(0, 3'd2, 32'h0003_0000, 0, c, d);
        access(0, 3'd2, 32'h0003_0004, 0, c, d);
        access(0, 3'd2, 32'h0003_0000, 0, c, d);
        access(0, 3'd0, 32'h0003_0001, 0, c, d);
        access(1, 3'd2, 32'h0003_0004, 32'h1, c, d);
        compared += 2;
        if (hit_count !== 32'd5) begin mismatched++; $display("FAIL hit_count: got %0d want 5", hit_count); end
        if (miss_count !== 32'd2) begin mismatched++; $display("FAIL miss_count: got %0d want 2", miss_count); end
    endtask
`endif

    initial begin
        for (int i = 0; i < S; i++) begin mv[i] = 0; md[i] = 0; mt[i] = 0; end
        test_reset();
        test_directed();
        test_reset_mid();
        test_random();
        test_back_to_back();
`ifdef DCACHE_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate cache controller that sits between the pipeline's memory stage and the byte-addressed data memory.
- Holds one 32-bit word per line, plus tag, valid and dirty arrays.
- Sequences dirty-victim writeback and line refill over the data memory's word port, and stalls the pipeline while a miss is being serviced.
- Performs load extraction (LB/LH/LW/LBU/LHU) and store merging (SB/SH/SW) on cached words.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width; fixed at 32 (line = 1 word).
- SETS, 8, number of lines; power of 2, minimum 2.
- MEM_LATENCY, 2, cycles per memory transfer; minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  memory-stage access present.
- req_write  in  1  1 = store, 0 = load.
- func3  in  3  RISC-V width/sign code.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data; valid bytes are LSB-aligned.
- stall  out  1  freeze pipeline; the request must be held stable.
- rdata  out  DATA_WIDTH  extended load result, valid when stall=0.
- mem_addr  out  ADDR_WIDTH  word-aligned memory address.
- mem_wdata  out  DATA_WIDTH  writeback word.
- mem_wen  out  1  writeback strobe.
- mem_ren  out  1  refill read enable.
- mem_rdata  in  DATA_WIDTH  refill word; sampled on the last refill cycle.

Behaviour:
- Address split:
  - off = addr[1:0].
  - idx = addr[2 +: log2(SETS)].
  - tag = the remaining upper bits.
- Hit = req_valid & valid[idx] & (tag_arr[idx] == tag).
- Reset (async) values:
  - Controller state: state=IDLE, cnt=0, all valid=0, all dirty=0.
  - Outputs: stall=0, mem_wen=0, mem_ren=0, mem_addr=0, mem_wdata=0, rdata=0.
- States: IDLE, WRITEBACK, REFILL.
- IDLE, no request (req_valid=0): no action, stall=0.
- IDLE, load hit:
  - rdata is combinational from the line, stall=0 (zero extra cycles).
  - Load extraction from the word:
    - LB/LBU select the byte at off, sign- or zero-extended.
    - LH/LHU select the half at off[1], sign- or zero-extended.
    - LW returns the whole word.
    - Other func3 values return 0.
- IDLE, store hit:
  - Bytes are merged at the clk edge and dirty[idx] is set; stall=0.
  - SB writes the byte at off; SH writes the half at off[1]; SW writes the whole word.
  - Other func3 values are treated as SW.
- IDLE, miss, clean or invalid victim:
  - stall=1 combinationally.
  - Latch req_addr into miss_addr and go to REFILL with cnt=0.
- IDLE, miss, valid and dirty victim:
  - stall=1 combinationally.
  - Latch miss_addr and go to WRITEBACK with cnt=0.
- WRITEBACK:
  - mem_addr = {victim tag, idx, 2'b00}; mem_wdata = victim word.
  - mem_wen=1 for the first WRITEBACK cycle only.
  - Stay MEM_LATENCY cycles, then clear dirty and go to REFILL with cnt=0.
- REFILL:
  - mem_ren=1 and mem_addr = {miss_addr[ADDR_WIDTH-1:2], 2'b00}.
  - On cycle MEM_LATENCY-1: write mem_rdata into the line, set tag and valid, clear dirty, go to IDLE.
- After a miss: in the IDLE cycle after REFILL, the held request hits.
  - A load returns data with stall=0.
  - A store merges and sets dirty.
- Miss cost:
  - Clean miss: MEM_LATENCY+1 stall cycles.
  - Dirty miss: 2*MEM_LATENCY+1 stall cycles.
- stall=1 throughout WRITEBACK and REFILL.
- WRITEBACK and REFILL use the latched miss_addr; req changes during a miss are ignored until IDLE.
- Counter cnt is log2(MEM_LATENCY)+1 bits wide, resets to 0 on every state entry, and never wraps within a state.
- Reset mid-operation:
  - State returns to IDLE; mem_wen and mem_ren drop immediately; all lines are invalidated.
  - An in-flight writeback is abandoned (software-visible loss is accepted).
- mem_wen and mem_ren are never high in the same cycle.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- When defined:
  - Adds outputs hit_count and miss_count, 32 bits each, both reset to 0.
  - hit_count increments once per request that completes in IDLE without a miss: each first-try hit, plus the post-refill access.
  - miss_count increments once per IDLE miss detection.
  - Both counters saturate at 32'hFFFF_FFFF.
- When undefined: the ports and counter logic are absent; behaviour is otherwise identical.

Decomposition:
- Package dcache_pkg holds:
  - The state enum typedef (IDLE/WRITEBACK/REFILL).
  - func3 localparams: LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=0, SH=1, SW=2.
- One sub-module, dcache_align: combinational load extract/extend and store byte-merge, keyed by func3 and off.
- Tag, valid and dirty arrays plus the FSM live in the top module.

Test Plan:
- Reset, then LW 0x00010000 → stall=1 for 3 cycles (MEM_LATENCY=2) with mem_ren=1 and mem_addr=0x00010000; then rdata = mem word, stall=0.
- LB hit at 0x00010003 where the word is 0x80FF_1234 → rdata=0xFFFFFF80; LBU at the same address → 0x00000080.
- SB 0xAB at 0x00010001 on a hit → no stall; a following LW returns 0x80FF_AB34.
- Load 0x00010020 (same idx, different tag) while the line is dirty → mem_wen=1 for one cycle with mem_addr=0x00010000 and mem_wdata=0x80FF_AB34; then 2 REFILL cycles; 5 stall cycles total.
- Assert rst during REFILL cycle 1 → mem_ren=0 immediately, state=IDLE, the next LW to the same address misses again.
- With DCACHE_STATS_EN defined, run 3 hits and 2 misses → hit_count=5 (including 2 post-refill completions), miss_count=2.
